muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle controller for the iterative multiply/divide resource, driven by the ALU control codes for mul (5) and div (4). It accepts one operation from the execute stage and runs a WIDTH-iteration shift-add multiply or restoring divide. While running it holds the pipeline with stall and delivers a HI/LO result with a one-cycle done pulse. All other ALU control codes are ignored and stay on the single-cycle ALU path.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request from execute stage, sampled on rising edge
op  input  4  ALU control code: 4'd5 = mul, 4'd4 = div, anything else = no request
a  input  WIDTH  multiplicand / dividend (unsigned)
b  input  WIDTH  multiplier / divisor (unsigned)
busy  output  1  high whenever the FSM is not IDLE
stall  output  1  pipeline hold request
done  output  1  one-cycle pulse; hi/lo valid
hi  output  WIDTH  product upper half / remainder
lo  output  WIDTH  product lower half / quotient
div_by_zero  output  1  sticky until next accepted start; set for div with b==0

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; hi, lo, busy, done, div_by_zero all 0; counter 0; internal accumulators 0. No done pulse is produced for an aborted operation.
- States: IDLE, MUL, DIV, FIN.
- IDLE: start=1 with op==5 latches a and b, clears the accumulator, sets counter=WIDTH, and goes to MUL. start=1 with op==4 and b!=0 does the same and goes to DIV. start=1 with op==4 and b==0 goes to FIN with div_by_zero=1, hi=a, lo={WIDTH{1'b1}}. Any other op, or start=0, stays in IDLE. An accepted start clears div_by_zero unless it is itself a divide by zero.
- MUL: one shift-add step per cycle on the 2*WIDTH accumulator, counter decrements. When counter reaches 1, the final step completes and the FSM goes to FIN.
- DIV: one restoring step per cycle (shift remainder, trial-subtract divisor, set quotient bit), counter decrements. When counter reaches 1, the FSM goes to FIN.
- FIN: hi and lo are loaded and done=1 for exactly this cycle. Next state is always IDLE.
- Latency: with the start edge at cycle 0, done=1 in cycle WIDTH+1 (33 for the default) for mul and for div with b!=0. For div-by-zero, done=1 in cycle 1.
- hi and lo hold their value from FIN until the next FIN or reset. They never change during MUL or DIV.
- busy = (state != IDLE), registered.
- stall = busy OR (start AND state==IDLE AND op in {4,5}). This is combinational, so the issuing instruction freezes in the same cycle. stall deasserts in the FIN cycle so the consumer can capture hi/lo on that edge.
- start while busy is ignored; the operation in flight is unaffected.
- A start arriving in the FIN cycle is ignored; the requester retries in IDLE (stall is 0 in FIN, so the pipeline must not re-issue until done is seen).
- Arithmetic is unsigned. The mul product is exact at 2*WIDTH bits. For div, quotient = floor(a/b) and remainder = a - quotient*b.

Decomposition:
- Shared header muldiv_defs: ALU_MUL=4'd5, ALU_DIV=4'd4, and the state encodings (IDLE=2'd0, MUL=2'd1, DIV=2'd2, FIN=2'd3). The ALU control decoder and this block both include it.
- Sub-module muldiv_step: combinational single-iteration datapath (shift-add or trial-subtract) selected by mode. It holds no state. The sequencer owns the FSM, counter and registers.

Test Plan:
- mul a=7, b=6, start at cycle 0 -> stall=1 in cycle 0, busy for cycles 1..33, done=1 in cycle 33 only, hi=0, lo=42, div_by_zero=0.
- mul a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at done; hi/lo unchanged before done.
- div a=100, b=7 -> lo=14, hi=2 at cycle 33; then div a=5, b=9 -> lo=0, hi=5.
- div a=0x1234, b=0 -> done=1 in cycle 1, div_by_zero=1, hi=0x1234, lo=0xFFFFFFFF; a following mul 3*3 clears the flag and gives lo=9.
- start with op=5 during cycle 10 of a running div, and start with op=2 while IDLE -> both ignored: the div result is correct at cycle 33, the op=2 request produces no busy, stall or done, and hi/lo are unchanged.
- Reset asserted asynchronously mid-MUL at cycle 15 -> immediately busy=0, stall=0, hi=lo=0, no done pulse; after release, mul 2*3 completes normally with lo=6.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU control codes,
// FSM state encoding and the datapath step mode.
package muldiv_sequencer_pkg;

  localparam logic [3:0] ALU_DIV = 4'd4;
  localparam logic [3:0] ALU_MUL = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } step_mode_e;

  // True for the two ALU codes that are routed to the multi-cycle unit.
  function automatic logic is_muldiv_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> multiply/divide sequencer handshake and result bus.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  // Execute stage issues requests and consumes results.
  modport master (
    output start, op, a, b,
    input  busy, stall, done, hi, lo, div_by_zero
  );

  // Sequencer accepts requests and produces results.
  modport slave (
    input  start, op, a, b,
    output busy, stall, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer_step.sv
// One iteration of the shared multiply/divide datapath. Purely combinational.
// The 2*WIDTH accumulator is {upper, lower}:
//   mul: upper = partial product, lower = remaining multiplier bits (LSB first)
//   div: upper = partial remainder, lower = dividend bits shifting into quotient
module muldiv_sequencer_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  step_mode_e         mode,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] diff_s;
  logic             fits_s;

  // Shift-add for mul, shift/trial-subtract/restore for div, selected by mode.
  always_comb begin
    sum_s     = {(WIDTH+1){1'b0}};
    shifted_s = {(WIDTH+1){1'b0}};
    diff_s    = {WIDTH{1'b0}};
    fits_s    = 1'b0;
    acc_out   = acc_in;
    case (mode)
      MODE_MUL: begin
        if (acc_in[0]) begin
          sum_s = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        end else begin
          sum_s = {1'b0, acc_in[2*WIDTH-1:WIDTH]};
        end
        // Carry out of the add becomes the new MSB after the right shift.
        acc_out = {sum_s, acc_in[WIDTH-1:1]};
      end
      MODE_DIV: begin
        shifted_s = acc_in[2*WIDTH-1:WIDTH-1];
        fits_s    = (shifted_s >= {1'b0, operand});
        // When the divisor fits the difference is below the divisor, so WIDTH bits suffice.
        diff_s    = shifted_s[WIDTH-1:0] - operand;
        if (fits_s) begin
          acc_out = {diff_s, acc_in[WIDTH-2:0], 1'b1};
        end else begin
          acc_out = {shifted_s[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        acc_out = acc_in;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle controller for the iterative multiply/divide unit. Accepts one
// mul/div from execute, holds the pipeline while iterating, and returns HI/LO
// with a single-cycle done pulse.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  state_e             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] step_acc_s;
  logic [WIDTH-1:0]   operand_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r, dbz_r;
  logic               req_s, b_zero_s;
  step_mode_e         mode_s;

  assign b_zero_s = (bus.b == {WIDTH{1'b0}});
  assign req_s    = bus.start && (state_r == ST_IDLE) && is_muldiv_op(bus.op);

  // Freeze the issuing instruction immediately; release in FIN so hi/lo can be captured.
  assign bus.stall       = (state_r == ST_MUL) || (state_r == ST_DIV) || req_s;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;

  // Select datapath mode from the running operation.
  always_comb begin
    if (state_r == ST_DIV) begin
      mode_s = MODE_DIV;
    end else begin
      mode_s = MODE_MUL;
    end
  end

  muldiv_sequencer_step #(.WIDTH(WIDTH)) u_step (
    .mode    (mode_s),
    .acc_in  (acc_r),
    .operand (operand_r),
    .acc_out (step_acc_s)
  );

  // Next-state logic: accept in IDLE, iterate until the last step, one FIN cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && (bus.op == ALU_MUL)) begin
          state_s = ST_MUL;
        end else if (bus.start && (bus.op == ALU_DIV)) begin
          if (b_zero_s) begin
            state_s = ST_FIN;
          end else begin
            state_s = ST_DIV;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_r == CNT_ONE) begin
          state_s = ST_FIN;
        end else begin
          state_s = state_r;
        end
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, iteration registers and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      operand_r <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_FIN);
      case (state_r)
        ST_IDLE: begin
          if (bus.start && (bus.op == ALU_MUL)) begin
            acc_r     <= {{WIDTH{1'b0}}, bus.b};
            operand_r <= bus.a;
            cnt_r     <= CNT_INIT;
            dbz_r     <= 1'b0;
          end else if (bus.start && (bus.op == ALU_DIV) && !b_zero_s) begin
            acc_r     <= {{WIDTH{1'b0}}, bus.a};
            operand_r <= bus.b;
            cnt_r     <= CNT_INIT;
            dbz_r     <= 1'b0;
          end else if (bus.start && (bus.op == ALU_DIV)) begin
            // Divide by zero: no iteration, fixed result in FIN.
            acc_r <= {(2*WIDTH){1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            hi_r  <= bus.a;
            lo_r  <= {WIDTH{1'b1}};
            dbz_r <= 1'b1;
          end
        end
        ST_MUL, ST_DIV: begin
          acc_r <= step_acc_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            hi_r <= step_acc_s[2*WIDTH-1:WIDTH];
            lo_r <= step_acc_s[WIDTH-1:0];
          end
        end
        ST_FIN: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
  endtask

  // Called at posedge+1 of cycle 0. Optionally injects a mul request at inj_cyc.
  task automatic run_op(input string tag, input logic [3:0] op_v,
                        input logic [31:0] a_v, input logic [31:0] b_v,
                        input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz,
                        input int inj_cyc);
    int done_cyc;
    int done_cnt;
    int bad_ctl;
    int bad_hold;
    bus.start = 1'b1;
    bus.op    = op_v;
    bus.a     = a_v;
    bus.b     = b_v;
    @(negedge clk);
    check_value({tag, "_stall_c0"}, {63'd0, bus.stall}, 64'd1);
    check_value({tag, "_busy_c0"}, {63'd0, bus.busy}, 64'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    done_cyc = -1;
    done_cnt = 0;
    bad_ctl  = 0;
    bad_hold = 0;
    for (int c = 1; c <= exp_lat + 3; c++) begin
      if (c == inj_cyc) begin
        bus.start = 1'b1;
        bus.op    = ALU_MUL;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c < exp_lat && (!bus.busy || !bus.stall)) bad_ctl++;
      if (c > exp_lat && (bus.busy || bus.stall)) bad_ctl++;
      if (c < exp_lat && (bus.hi !== cur_hi || bus.lo !== cur_lo)) bad_hold++;
      if (c == exp_lat) begin
        check_value({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        check_value({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
        check_value({tag, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, exp_dbz});
        check_value({tag, "_busy_fin"}, {63'd0, bus.busy}, 64'd1);
        check_value({tag, "_stall_fin"}, {63'd0, bus.stall}, 64'd0);
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check_value({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_lat));
    check_value({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check_value({tag, "_ctl_errs"}, 64'(bad_ctl), 64'd0);
    check_value({tag, "_hold_errs"}, 64'(bad_hold), 64'd0);
    check_value({tag, "_hi_after"}, {32'd0, bus.hi}, {32'd0, exp_hi});
    check_value({tag, "_dbz_after"}, {63'd0, bus.div_by_zero}, {63'd0, exp_dbz});
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  initial begin
    int bad;
    int dn;
    n_vec  = 0;
    n_miss = 0;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    idle_inputs();
    reset = 1'b1;
    #12;
    check_value("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_value("rst_done", {63'd0, bus.done}, 64'd0);
    check_value("rst_stall", {63'd0, bus.stall}, 64'd0);
    check_value("rst_hi", {32'd0, bus.hi}, 64'd0);
    check_value("rst_lo", {32'd0, bus.lo}, 64'd0);
    check_value("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("mul_7x6", ALU_MUL, 32'd7, 32'd6, 33, 32'd0, 32'd42, 1'b0, 0);
    run_op("mul_max", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op("div_100_7", ALU_DIV, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 0);
    run_op("div_5_9", ALU_DIV, 32'd5, 32'd9, 33, 32'd5, 32'd0, 1'b0, 0);
    run_op("div_max_1", ALU_DIV, 32'hFFFF_FFFF, 32'd1, 33, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("div_by_0", ALU_DIV, 32'h0000_1234, 32'd0, 1, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("mul_3x3", ALU_MUL, 32'd3, 32'd3, 33, 32'd0, 32'd9, 1'b0, 0);
    run_op("div_inj", ALU_DIV, 32'd1000, 32'd33, 33, 32'd10, 32'd30, 1'b0, 10);

    // Non-muldiv op while idle must be invisible.
    bad = 0;
    bus.start = 1'b1;
    bus.op    = 4'd2;
    bus.a     = 32'd11;
    bus.b     = 32'd12;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.busy || bus.stall || bus.done) bad++;
      if (bus.hi !== cur_hi || bus.lo !== cur_lo) bad++;
      @(posedge clk);
      #1;
      idle_inputs();
    end
    check_value("op2_ignored", 64'(bad), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    bus.start = 1'b1;
    bus.op    = ALU_MUL;
    bus.a     = 32'd1234;
    bus.b     = 32'd5678;
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (14) @(posedge clk);
    #4;
    check_value("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    #1;
    check_value("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check_value("midrst_stall", {63'd0, bus.stall}, 64'd0);
    check_value("midrst_hi", {32'd0, bus.hi}, 64'd0);
    check_value("midrst_lo", {32'd0, bus.lo}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    check_value("midrst_no_done", 64'(dn), 64'd0);
    @(posedge clk);
    #1;
    run_op("mul_2x3", ALU_MUL, 32'd2, 32'd3, 33, 32'd0, 32'd6, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
